// File: rtl/e203_extend_csr_arb.sv
// e203_extend_csr_arb
// Two-requester arbiter/sequencer for the extended-CSR (NICE CSR) port.
// Requester 0 is the EXU CSR path and requester 1 is the debug abstract-CSR path.
// Accesses are serialised onto one nice_csr_* port. The read data is
// registered and returned to whichever requester owns the access.
//
// Handshake: on every channel a transfer happens in a cycle where valid and
// ready are both 1. A requester may drop valid before it is granted. Once
// granted, the access is committed. Downstream request fields and response
// fields stay stable while valid=1 and ready=0.
//
// Optional build macro: E203_EXTEND_CSR_ARB_TMO_EN adds a REQ watchdog. After
// TMO_CYC stalled cycles the access completes with err=1 and rdata=0. Without
// the macro, REQ waits indefinitely and err is tied to 0.
//
// o_dbg_state exposes the FSM state: 0 = IDLE, 1 = REQ, 2 = RSP.
module e203_extend_csr_arb #(
    parameter int         ARB_RR  = 0,
    parameter logic [7:0] TMO_CYC = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_csr_valid,
    output logic        r0_csr_ready,
    input  logic [31:0] r0_csr_addr,
    input  logic        r0_csr_wr,
    input  logic [31:0] r0_csr_wdata,
    output logic        r0_rsp_valid,
    input  logic        r0_rsp_ready,
    output logic [31:0] r0_rsp_rdata,
    output logic        r0_rsp_err,
    input  logic        r1_csr_valid,
    output logic        r1_csr_ready,
    input  logic [31:0] r1_csr_addr,
    input  logic        r1_csr_wr,
    input  logic [31:0] r1_csr_wdata,
    output logic        r1_rsp_valid,
    input  logic        r1_rsp_ready,
    output logic [31:0] r1_rsp_rdata,
    output logic        r1_rsp_err,
    output logic        nice_csr_valid,
    input  logic        nice_csr_ready,
    output logic [31:0] nice_csr_addr,
    output logic        nice_csr_wr,
    output logic [31:0] nice_csr_wdata,
    input  logic [31:0] nice_csr_rdata,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_rr_ptr;
    logic        r_owner;
    logic        r_wr;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [1:0]  w_gnt;
    logic        w_rsp_ready;
    logic        w_tmo_hit;
    logic        w_err;

    // Grant is combinational and only offered in IDLE. A lone requester always wins.
    always_comb begin
        w_gnt = 2'b00;
        if (r_state == ST_IDLE) begin
            if (r0_csr_valid && r1_csr_valid) begin
                if ((ARB_RR != 0) && r_rr_ptr) begin
                    w_gnt = 2'b10;
                end else begin
                    w_gnt = 2'b01;
                end
            end else if (r0_csr_valid) begin
                w_gnt = 2'b01;
            end else if (r1_csr_valid) begin
                w_gnt = 2'b10;
            end
        end
    end

    assign w_rsp_ready = r_owner ? r1_rsp_ready : r0_rsp_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. A downstream accept takes priority over a watchdog expiry.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt != 2'b00) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (nice_csr_ready || w_tmo_hit) begin
                    w_state_nxt = ST_RSP;
                end
            end
            ST_RSP: begin
                if (w_rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Capture the granted request and the downstream read data.
    // rr_ptr points at the requester that lost the most recent grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= 1'b0;
            r_owner  <= 1'b0;
            r_wr     <= 1'b0;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_rdata  <= 32'h0;
        end else begin
            if (w_gnt != 2'b00) begin
                r_owner  <= w_gnt[1];
                r_rr_ptr <= ~w_gnt[1];
                r_wr     <= w_gnt[1] ? r1_csr_wr    : r0_csr_wr;
                r_addr   <= w_gnt[1] ? r1_csr_addr  : r0_csr_addr;
                r_wdata  <= w_gnt[1] ? r1_csr_wdata : r0_csr_wdata;
            end
            if (r_state == ST_REQ) begin
                if (nice_csr_ready) begin
                    r_rdata <= r_wr ? 32'h0 : nice_csr_rdata;
                end else if (w_tmo_hit) begin
                    r_rdata <= 32'h0;
                end
            end
        end
    end

`ifdef E203_EXTEND_CSR_ARB_TMO_EN
    logic [7:0] r_tmo_cnt;
    logic       r_err;

    // Expire on the stalled REQ cycle that would bring the count up to TMO_CYC.
    assign w_tmo_hit = (r_state == ST_REQ) && !nice_csr_ready &&
                       (({1'b0, r_tmo_cnt} + 9'd1) >= {1'b0, TMO_CYC});
    assign w_err     = r_err;

    // Watchdog counter: clear on entry to REQ, count stalled cycles, saturate at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= 8'h0;
            r_err     <= 1'b0;
        end else begin
            if (w_gnt != 2'b00) begin
                r_tmo_cnt <= 8'h0;
            end else if ((r_state == ST_REQ) && !nice_csr_ready && (r_tmo_cnt != 8'hFF)) begin
                r_tmo_cnt <= r_tmo_cnt + 8'd1;
            end
            if ((r_state == ST_REQ) && nice_csr_ready) begin
                r_err <= 1'b0;
            end else if (w_tmo_hit) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    assign w_tmo_hit = 1'b0;
    assign w_err     = 1'b0;
`endif

    assign r0_csr_ready   = w_gnt[0];
    assign r1_csr_ready   = w_gnt[1];

    assign nice_csr_valid = (r_state == ST_REQ);
    assign nice_csr_addr  = r_addr;
    assign nice_csr_wr    = r_wr;
    assign nice_csr_wdata = r_wdata;

    // The response is routed to the owner only; the other requester sees zeros.
    assign r0_rsp_valid   = (r_state == ST_RSP) && !r_owner;
    assign r1_rsp_valid   = (r_state == ST_RSP) && r_owner;
    assign r0_rsp_rdata   = r_owner ? 32'h0 : r_rdata;
    assign r1_rsp_rdata   = r_owner ? r_rdata : 32'h0;
    assign r0_rsp_err     = r0_rsp_valid && w_err;
    assign r1_rsp_err     = r1_rsp_valid && w_err;

    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_e203_extend_csr_arb.sv
// Testbench for e203_extend_csr_arb.
// Two instances share all inputs: instance 0 uses fixed priority and instance 1
// uses round-robin. The expected grants and responses come from a
// transaction-level model of the arbitration rules.
module tb_e203_extend_csr_arb;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic [1:0]  csr_valid;
    logic [1:0]  csr_wr;
    logic [1:0]  rsp_ready;
    logic [31:0] csr_addr  [2];
    logic [31:0] csr_wdata [2];
    logic        nice_ready;
    logic [31:0] nice_rdata;

    logic [1:0]  o_csr_ready  [2];
    logic [1:0]  o_rsp_valid  [2];
    logic [1:0]  o_rsp_err    [2];
    logic [31:0] o_rsp_rdata  [2][2];
    logic        o_nice_valid [2];
    logic [31:0] o_nice_addr  [2];
    logic        o_nice_wr    [2];
    logic [31:0] o_nice_wdata [2];
    logic [1:0]  o_dbg        [2];

    generate
        for (genvar m = 0; m < 2; m++) begin : g_dut
            e203_extend_csr_arb #(.ARB_RR(m), .TMO_CYC(8'd4)) u_dut (
                .clk            (clk),
                .rst            (rst),
                .r0_csr_valid   (csr_valid[0]),
                .r0_csr_ready   (o_csr_ready[m][0]),
                .r0_csr_addr    (csr_addr[0]),
                .r0_csr_wr      (csr_wr[0]),
                .r0_csr_wdata   (csr_wdata[0]),
                .r0_rsp_valid   (o_rsp_valid[m][0]),
                .r0_rsp_ready   (rsp_ready[0]),
                .r0_rsp_rdata   (o_rsp_rdata[m][0]),
                .r0_rsp_err     (o_rsp_err[m][0]),
                .r1_csr_valid   (csr_valid[1]),
                .r1_csr_ready   (o_csr_ready[m][1]),
                .r1_csr_addr    (csr_addr[1]),
                .r1_csr_wr      (csr_wr[1]),
                .r1_csr_wdata   (csr_wdata[1]),
                .r1_rsp_valid   (o_rsp_valid[m][1]),
                .r1_rsp_ready   (rsp_ready[1]),
                .r1_rsp_rdata   (o_rsp_rdata[m][1]),
                .r1_rsp_err     (o_rsp_err[m][1]),
                .nice_csr_valid (o_nice_valid[m]),
                .nice_csr_ready (nice_ready),
                .nice_csr_addr  (o_nice_addr[m]),
                .nice_csr_wr    (o_nice_wr[m]),
                .nice_csr_wdata (o_nice_wdata[m]),
                .nice_csr_rdata (nice_rdata),
                .o_dbg_state    (o_dbg[m])
            );
        end
    endgenerate

    int n_chk  = 0;
    int n_fail = 0;

    // Model state: the round-robin pointer of each instance.
    int rr_model [2];

    // Stimulus for one access.
    logic [1:0]  t_mask;
    logic [1:0]  t_wr;
    logic [31:0] t_addr  [2];
    logic [31:0] t_wdata [2];
    logic [31:0] t_rd;
    int          t_stall;
    int          t_bp;

    task automatic chk(input string tag, input int m, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, m, obs, exp);
        end
    endtask

    task automatic drive_idle();
        csr_valid  = 2'b00;
        csr_wr     = 2'b00;
        rsp_ready  = 2'b00;
        nice_ready = 1'b0;
        nice_rdata = 32'h0;
        csr_addr[0] = 32'h0; csr_addr[1] = 32'h0;
        csr_wdata[0] = 32'h0; csr_wdata[1] = 32'h0;
    endtask

    // One full access: grant cycle, t_stall stalled REQ cycles plus one accepting cycle,
    // t_bp back-pressured RSP cycles plus one accepting cycle, then an IDLE check.
    task automatic do_access();
        int          win    [2];
        logic [31:0] exp_rd [2];
        for (int m = 0; m < 2; m++) begin
            if (t_mask != 2'b11) win[m] = t_mask[1] ? 1 : 0;
            else                 win[m] = (m == 1) ? rr_model[m] : 0;
            rr_model[m] = 1 - win[m];
            exp_rd[m] = t_wr[win[m]] ? 32'h0 : t_rd;
        end
        @(negedge clk);
        csr_valid = t_mask; csr_wr = t_wr; csr_addr = t_addr; csr_wdata = t_wdata;
        nice_ready = 1'b0; rsp_ready = 2'b00;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("grant", m, o_csr_ready[m], 2'b01 << win[m]);
            chk("idle_nice_valid", m, o_nice_valid[m], 1'b0);
        end
        for (int c = 0; c <= t_stall; c++) begin
            @(negedge clk);
            csr_valid = 2'($urandom_range(0, 3));
            csr_addr[0] = $urandom; csr_addr[1] = $urandom;
            csr_wdata[0] = $urandom; csr_wdata[1] = $urandom;
            csr_wr = 2'($urandom_range(0, 3));
            nice_ready = (c == t_stall);
            nice_rdata = (c == t_stall) ? t_rd : $urandom;
            #1;
            for (int m = 0; m < 2; m++) begin
                chk("req_valid", m, o_nice_valid[m], 1'b1);
                chk("req_addr", m, o_nice_addr[m], t_addr[win[m]]);
                chk("req_wr", m, o_nice_wr[m], t_wr[win[m]]);
                chk("req_wdata", m, o_nice_wdata[m], t_wdata[win[m]]);
                chk("req_no_grant", m, o_csr_ready[m], 2'b00);
                chk("req_no_rsp", m, o_rsp_valid[m], 2'b00);
            end
        end
        for (int c = 0; c <= t_bp; c++) begin
            @(negedge clk);
            csr_valid = 2'($urandom_range(0, 3));
            nice_ready = 1'($urandom_range(0, 1));
            nice_rdata = $urandom;
            rsp_ready = (c == t_bp) ? 2'b11 : 2'b00;
            #1;
            for (int m = 0; m < 2; m++) begin
                chk("rsp_valid", m, o_rsp_valid[m], 2'b01 << win[m]);
                chk("rsp_rdata", m, o_rsp_rdata[m][win[m]], exp_rd[m]);
                chk("rsp_err", m, o_rsp_err[m], 2'b00);
                chk("rsp_nice_valid", m, o_nice_valid[m], 1'b0);
                chk("rsp_no_grant", m, o_csr_ready[m], 2'b00);
            end
        end
        @(negedge clk);
        drive_idle();
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("back_to_idle", m, o_dbg[m], 2'd0);
            chk("idle_no_rsp", m, o_rsp_valid[m], 2'b00);
        end
    endtask

    initial begin
        int held;
        int exp_win;
        rr_model[0] = 0; rr_model[1] = 0;
        rst = 1'b1;
        drive_idle();

        // Reset state.
        @(negedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("rst_state", m, o_dbg[m], 2'd0);
            chk("rst_nice_valid", m, o_nice_valid[m], 1'b0);
            chk("rst_nice_addr", m, o_nice_addr[m], 32'h0);
            chk("rst_nice_wdata", m, o_nice_wdata[m], 32'h0);
            chk("rst_rsp_valid", m, o_rsp_valid[m], 2'b00);
            chk("rst_rsp_err", m, o_rsp_err[m], 2'b00);
            chk("rst_rsp_rdata0", m, o_rsp_rdata[m][0], 32'h0);
            chk("rst_csr_ready", m, o_csr_ready[m], 2'b00);
        end
        @(negedge clk);
        rst = 1'b0;

        // Contention: both requesters valid every cycle for four accesses.
        @(negedge clk);
        csr_valid = 2'b11; nice_ready = 1'b1; rsp_ready = 2'b11; nice_rdata = 32'h5A5A_0001;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (cyc > 0) @(negedge clk);
            #1;
            for (int m = 0; m < 2; m++) begin
                if (cyc % 3 == 0) begin
                    exp_win = (m == 1) ? rr_model[m] : 0;
                    rr_model[m] = 1 - exp_win;
                    chk("contend_grant", m, o_csr_ready[m], 2'b01 << exp_win);
                end else begin
                    chk("contend_nogrant", m, o_csr_ready[m], 2'b00);
                end
            end
        end
        @(negedge clk);
        drive_idle();

        // Single read by r0.
        t_mask = 2'b01; t_wr = 2'b00; t_rd = 32'hDEAD_BEEF;
        t_addr[0] = 32'h0000_0BC0; t_addr[1] = 32'h0;
        t_wdata[0] = 32'h0; t_wdata[1] = 32'h0;
        t_stall = 0; t_bp = 0;
        do_access();

        // Write by r1 with a 3-cycle slave stall.
        t_mask = 2'b10; t_wr = 2'b10; t_rd = 32'hFFFF_0000;
        t_addr[1] = 32'h0000_0BC4; t_wdata[1] = 32'h1234_5678;
        t_stall = 3; t_bp = 0;
        do_access();

        // Response back-pressure for 5 cycles, with r1 knocking meanwhile.
        t_mask = 2'b01; t_wr = 2'b00; t_rd = 32'hCAFE_F00D;
        t_addr[0] = 32'h0000_0300; t_stall = 1; t_bp = 5;
        do_access();

        // Randomized accesses.
        for (int i = 0; i < 40; i++) begin
            t_mask = 2'($urandom_range(1, 3));
            t_wr = 2'($urandom_range(0, 3));
            t_addr[0] = $urandom; t_addr[1] = $urandom;
            t_wdata[0] = $urandom; t_wdata[1] = $urandom;
            t_rd = $urandom;
            t_stall = $urandom_range(0, 2);
            t_bp = $urandom_range(0, 3);
            do_access();
        end

        // Reset while in REQ.
        @(negedge clk);
        csr_valid = 2'b01; csr_addr[0] = 32'h0000_0777;
        @(negedge clk);
        csr_valid = 2'b00; nice_ready = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) chk("pre_rst_req", m, o_nice_valid[m], 1'b1);
        #1 rst = 1'b1;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("mid_rst_nice_valid", m, o_nice_valid[m], 1'b0);
            chk("mid_rst_state", m, o_dbg[m], 2'd0);
            chk("mid_rst_addr", m, o_nice_addr[m], 32'h0);
            chk("mid_rst_rsp_valid", m, o_rsp_valid[m], 2'b00);
        end
        @(negedge clk);
        rst = 1'b0;
        rr_model[0] = 0; rr_model[1] = 0;
        t_mask = 2'b10; t_wr = 2'b00; t_rd = 32'h0BAD_CAFE;
        t_addr[1] = 32'h0000_0BC8; t_stall = 0; t_bp = 0;
        do_access();

`ifdef E203_EXTEND_CSR_ARB_TMO_EN
        // Slave never ready: watchdog completes the access after 4 REQ cycles.
        @(negedge clk);
        csr_valid = 2'b01; csr_wr = 2'b00; csr_addr[0] = 32'h0000_0BCC;
        rr_model[0] = 1; rr_model[1] = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            csr_valid = 2'b00; nice_ready = 1'b0;
            #1;
            for (int m = 0; m < 2; m++) chk("tmo_req", m, o_nice_valid[m], 1'b1);
        end
        @(negedge clk);
        rsp_ready = 2'b11;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("tmo_nice_drop", m, o_nice_valid[m], 1'b0);
            chk("tmo_rsp_valid", m, o_rsp_valid[m], 2'b01);
            chk("tmo_rsp_err", m, o_rsp_err[m], 2'b01);
            chk("tmo_rsp_rdata", m, o_rsp_rdata[m][0], 32'h0);
        end
        @(negedge clk);
        drive_idle();
        #1;
        for (int m = 0; m < 2; m++) chk("tmo_idle", m, o_dbg[m], 2'd0);
`else
        // Slave never ready: REQ must persist indefinitely.
        @(negedge clk);
        csr_valid = 2'b01; csr_wr = 2'b00; csr_addr[0] = 32'h0000_0BCC;
        held = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            csr_valid = 2'b00; nice_ready = 1'b0;
            #1;
            if (o_nice_valid[0] && o_nice_valid[1] && (o_rsp_valid[0] == 2'b00) && (o_rsp_valid[1] == 2'b00))
                held++;
        end
        chk("req_persist", 0, held, 300);
        for (int m = 0; m < 2; m++) chk("req_persist_err", m, o_rsp_err[m], 2'b00);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
